// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// shift the working register right, then subtract 3 from every digit field that is >= 8.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   shifted;
    logic [SR_W-1:0]   adjusted;
    logic [CNT_W-1:0]  cnt;
    logic              bad_digit;
    logic              last_step;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse double-dabble step; all digit corrections see the same shifted value.
    always_comb begin
        shifted  = sr >> 1;
        adjusted = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
                adjusted[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    assign last_step = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = bad_digit ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result registers keep the last conversion after draining, until the next completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr      <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (bad_digit) begin
                            bin_out <= '0;
                            err     <= 1'b1;
                        end else begin
                            sr  <= {bcd_in, {BIN_W{1'b0}}};
                            cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= adjusted;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        bin_out <= adjusted[BIN_W-1:0];
                        err     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
